external_interrupt_unit: RTL and testbench



---
 rtl/external_interrupt_unit_if.sv | 38 +++
 rtl/external_interrupt_unit.sv | 112 +++++++++++
 tb/tb_external_interrupt_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/external_interrupt_unit_if.sv
// rtl/external_interrupt_unit_if.sv - pin, register and irq signals of the external interrupt unit
interface external_interrupt_unit_if;
  logic       pin_int0;
  logic       pin_int1;
  logic       pin_int2;
  logic       MCUCR_write_enable;
  logic [3:0] MCUCR_input_data;
  logic       ISC2_write_enable;
  logic       ISC2_input_data;
  logic       GICR_write_enable;
  logic [2:0] GICR_input_data;
  logic       GIFR_write_enable;
  logic [2:0] GIFR_input_data;
  logic       irq_ack;
  logic [1:0] irq_ack_vector;
  logic [3:0] MCUCR_output;
  logic       ISC2_output;
  logic [2:0] GICR_output;
  logic [2:0] GIFR_output;
  logic       irq_request;
  logic [1:0] irq_vector;

  modport master (
    output pin_int0, pin_int1, pin_int2,
    output MCUCR_write_enable, MCUCR_input_data, ISC2_write_enable, ISC2_input_data,
    output GICR_write_enable, GICR_input_data, GIFR_write_enable, GIFR_input_data,
    output irq_ack, irq_ack_vector,
    input  MCUCR_output, ISC2_output, GICR_output, GIFR_output, irq_request, irq_vector
  );

  modport slave (
    input  pin_int0, pin_int1, pin_int2,
    input  MCUCR_write_enable, MCUCR_input_data, ISC2_write_enable, ISC2_input_data,
    input  GICR_write_enable, GICR_input_data, GIFR_write_enable, GIFR_input_data,
    input  irq_ack, irq_ack_vector,
    output MCUCR_output, ISC2_output, GICR_output, GIFR_output, irq_request, irq_vector
  );
endinterface

// File: rtl/external_interrupt_unit.sv
// rtl/external_interrupt_unit.sv - INT0/INT1/INT2 synchroniser, sense logic, flag registers and prioritised irq
// Source bit order everywhere is {INT1, INT0, INT2}, matching GICR/GIFR.
module external_interrupt_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       clr,
  external_interrupt_unit_if.slave   bus
);
  localparam logic [2:0] WARM_END = 3'(SYNC_STAGES + 1);

  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] sync_d [SYNC_STAGES];
  logic [2:0] prev_q, prev_d;
  logic [2:0] warm_q, warm_d;
  logic [3:0] mcucr_q, mcucr_d;
  logic       isc2_q, isc2_d;
  logic [2:0] gicr_q, gicr_d;
  logic [2:0] gifr_q, gifr_d;
  logic [2:0] sync_lvl, rise, fall, edge_set, level, ack_clr, clr_mask, pending;
  logic       warm_done;
  logic [1:0] vector;

  function automatic logic isc_edge(input logic [1:0] isc, input logic r, input logic f);
    case (isc)
      2'b01:   return r | f;
      2'b10:   return f;
      2'b11:   return r;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    sync_d[0] = {bus.pin_int1, bus.pin_int0, bus.pin_int2};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    sync_lvl  = sync_q[SYNC_STAGES-1];
    prev_d    = sync_lvl;
    rise      = sync_lvl & ~prev_q;
    fall      = ~sync_lvl & prev_q;
    warm_done = (warm_q == WARM_END);
    warm_d    = warm_done ? warm_q : warm_q + 3'd1;

    edge_set = 3'b000;
    level    = 3'b000;
    if (warm_done) begin
      edge_set[2] = isc_edge(mcucr_q[3:2], rise[2], fall[2]);
      edge_set[1] = isc_edge(mcucr_q[1:0], rise[1], fall[1]);
      edge_set[0] = isc2_q ? rise[0] : fall[0];
      // Level sense taps the prev stage so it shares the edge-flag latency.
      level[2] = (mcucr_q[3:2] == 2'b00) & ~prev_q[2];
      level[1] = (mcucr_q[1:0] == 2'b00) & ~prev_q[1];
    end

    ack_clr = 3'b000;
    if (bus.irq_ack) begin
      case (bus.irq_ack_vector)
        2'd1:    ack_clr[1] = (mcucr_q[1:0] != 2'b00);
        2'd2:    ack_clr[2] = (mcucr_q[3:2] != 2'b00);
        2'd3:    ack_clr[0] = 1'b1;
        default: ack_clr = 3'b000;
      endcase
    end
    clr_mask = ack_clr | (bus.GIFR_write_enable ? bus.GIFR_input_data : 3'b000);
    gifr_d   = (gifr_q & ~clr_mask) | edge_set;

    mcucr_d = bus.MCUCR_write_enable ? bus.MCUCR_input_data : mcucr_q;
    isc2_d  = bus.ISC2_write_enable  ? bus.ISC2_input_data  : isc2_q;
    gicr_d  = bus.GICR_write_enable  ? bus.GICR_input_data  : gicr_q;

    pending = (gifr_q | level) & gicr_q;
    if (pending[1])      vector = 2'd1;
    else if (pending[2]) vector = 2'd2;
    else if (pending[0]) vector = 2'd3;
    else                 vector = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 3'b000;
      end
      prev_q  <= 3'b000;
      warm_q  <= 3'd0;
      mcucr_q <= 4'b0000;
      isc2_q  <= 1'b0;
      gicr_q  <= 3'b000;
      gifr_q  <= 3'b000;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q  <= prev_d;
      warm_q  <= warm_d;
      mcucr_q <= mcucr_d;
      isc2_q  <= isc2_d;
      gicr_q  <= gicr_d;
      gifr_q  <= gifr_d;
    end
  end

  assign bus.MCUCR_output = mcucr_q;
  assign bus.ISC2_output  = isc2_q;
  assign bus.GICR_output  = gicr_q;
  assign bus.GIFR_output  = gifr_q;
  assign bus.irq_request  = |pending;
  assign bus.irq_vector   = vector;
endmodule

// File: tb/tb_external_interrupt_unit.sv
// tb/tb_external_interrupt_unit.sv - directed and randomized checks of external_interrupt_unit against a pin-history model
module tb_external_interrupt_unit;
  localparam int S = 2;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   total = 0;
  int   bad = 0;

  // Model: h[i] is the pin vector {INT1,INT0,INT2} present at the edge i cycles ago.
  logic [3:0] m_mcucr;
  logic       m_isc2;
  logic [2:0] m_gicr;
  logic [2:0] m_gifr;
  logic [2:0] h [S+2];
  int         since;

  external_interrupt_unit_if bus ();
  external_interrupt_unit #(.SYNC_STAGES(S)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic isc_hit(input logic [1:0] isc, input logic cur, input logic old);
    if (isc == 2'b01) return cur != old;
    if (isc == 2'b10) return old && !cur;
    if (isc == 2'b11) return cur && !old;
    return 1'b0;
  endfunction

  function automatic logic [2:0] m_pending();
    logic [2:0] lv;
    lv = 3'b000;
    if (since >= S + 1) begin
      lv[2] = (m_mcucr[3:2] == 2'b00) && !h[S][2];
      lv[1] = (m_mcucr[1:0] == 2'b00) && !h[S][1];
    end
    return (m_gifr | lv) & m_gicr;
  endfunction

  function automatic logic [1:0] m_vector(input logic [2:0] p);
    if (p[1]) return 2'd1;
    if (p[2]) return 2'd2;
    if (p[0]) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_edge();
    logic [2:0] setv, clrv;
    if (clr) begin
      m_mcucr = 4'b0000; m_isc2 = 1'b0; m_gicr = 3'b000; m_gifr = 3'b000; since = 0;
      for (int i = 0; i < S + 2; i++) h[i] = 3'b000;
      return;
    end
    for (int i = S + 1; i > 0; i--) h[i] = h[i-1];
    h[0] = {bus.pin_int1, bus.pin_int0, bus.pin_int2};
    since++;
    setv = 3'b000;
    if (since >= S + 2) begin
      setv[2] = isc_hit(m_mcucr[3:2], h[S][2], h[S+1][2]);
      setv[1] = isc_hit(m_mcucr[1:0], h[S][1], h[S+1][1]);
      setv[0] = m_isc2 ? (h[S][0] && !h[S+1][0]) : (!h[S][0] && h[S+1][0]);
    end
    clrv = bus.GIFR_write_enable ? bus.GIFR_input_data : 3'b000;
    if (bus.irq_ack) begin
      if (bus.irq_ack_vector == 2'd1 && m_mcucr[1:0] != 2'b00) clrv[1] = 1'b1;
      if (bus.irq_ack_vector == 2'd2 && m_mcucr[3:2] != 2'b00) clrv[2] = 1'b1;
      if (bus.irq_ack_vector == 2'd3) clrv[0] = 1'b1;
    end
    m_gifr = (m_gifr & ~clrv) | setv;
    if (bus.MCUCR_write_enable) m_mcucr = bus.MCUCR_input_data;
    if (bus.ISC2_write_enable)  m_isc2  = bus.ISC2_input_data;
    if (bus.GICR_write_enable)  m_gicr  = bus.GICR_input_data;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2:0] p;
    p = m_pending();
    chk("mcucr", bus.MCUCR_output, m_mcucr);
    chk("isc2", {3'b000, bus.ISC2_output}, {3'b000, m_isc2});
    chk("gicr", {1'b0, bus.GICR_output}, {1'b0, m_gicr});
    chk("gifr", {1'b0, bus.GIFR_output}, {1'b0, m_gifr});
    chk("irq_request", {3'b000, bus.irq_request}, {3'b000, |p});
    chk("irq_vector", {2'b00, bus.irq_vector}, {2'b00, m_vector(p)});
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    bus.pin_int0 = 1'b1; bus.pin_int1 = 1'b1; bus.pin_int2 = 1'b0;
    bus.MCUCR_write_enable = 1'b0; bus.MCUCR_input_data = 4'h0;
    bus.ISC2_write_enable = 1'b0;  bus.ISC2_input_data = 1'b0;
    bus.GICR_write_enable = 1'b0;  bus.GICR_input_data = 3'b000;
    bus.GIFR_write_enable = 1'b0;  bus.GIFR_input_data = 3'b000;
    bus.irq_ack = 1'b0;            bus.irq_ack_vector = 2'd0;
    m_mcucr = 4'h0; m_isc2 = 1'b0; m_gicr = 3'b000; m_gifr = 3'b000; since = 0;
    for (int i = 0; i < S + 2; i++) h[i] = 3'b000;

    clr = 1'b1;
    cyc(2);
    chk("rst_gifr", {1'b0, bus.GIFR_output}, 4'h0);
    chk("rst_req", {3'b000, bus.irq_request}, 4'h0);
    chk("rst_vec", {2'b00, bus.irq_vector}, 4'h0);

    // Pin high from the first cycle, rising mode: warm-up must hide the fill edge.
    clr = 1'b0;
    bus.MCUCR_write_enable = 1'b1; bus.MCUCR_input_data = 4'b0011;
    cyc(1);
    bus.MCUCR_write_enable = 1'b0;
    chk("t1_mcucr", bus.MCUCR_output, 4'b0011);
    bus.GICR_write_enable = 1'b1; bus.GICR_input_data = 3'b010;
    cyc(1);
    bus.GICR_write_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("t1_gifr", {1'b0, bus.GIFR_output}, 4'h0);
      chk("t1_req", {3'b000, bus.irq_request}, 4'h0);
    end

    // Falling edge on INT0, then acknowledge.
    bus.MCUCR_write_enable = 1'b1; bus.MCUCR_input_data = 4'b0010;
    cyc(1);
    bus.MCUCR_write_enable = 1'b0;
    cyc(2);
    bus.pin_int0 = 1'b0;
    cyc(2);
    chk("t2_early", {1'b0, bus.GIFR_output}, 4'h0);
    cyc(1);
    chk("t2_gifr", {1'b0, bus.GIFR_output}, 4'h2);
    chk("t2_vec", {2'b00, bus.irq_vector}, 4'h1);
    bus.irq_ack = 1'b1; bus.irq_ack_vector = 2'd1;
    cyc(1);
    bus.irq_ack = 1'b0;
    chk("t2_ack_gifr", {1'b0, bus.GIFR_output}, 4'h0);
    chk("t2_ack_req", {3'b000, bus.irq_request}, 4'h0);

    // INT1 low-level for five cycles; ack mid-way has no effect.
    bus.GICR_write_enable = 1'b1; bus.GICR_input_data = 3'b100;
    cyc(1);
    bus.GICR_write_enable = 1'b0;
    cyc(2);
    bus.pin_int1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      bus.irq_ack = (k == 4); bus.irq_ack_vector = 2'd2;
      if (k == 5) bus.pin_int1 = 1'b1;
      chk("t3_req", {3'b000, bus.irq_request}, {3'b000, (k >= 3 && k <= 7)});
      chk("t3_gifr", {1'b0, bus.GIFR_output}, 4'h0);
    end
    bus.irq_ack = 1'b0;

    // Simultaneous rising edges on all three sources, acked in priority order.
    bus.MCUCR_write_enable = 1'b1; bus.MCUCR_input_data = 4'b1111;
    bus.ISC2_write_enable = 1'b1;  bus.ISC2_input_data = 1'b1;
    bus.GICR_write_enable = 1'b1;  bus.GICR_input_data = 3'b111;
    bus.pin_int1 = 1'b0;
    cyc(1);
    bus.MCUCR_write_enable = 1'b0; bus.ISC2_write_enable = 1'b0; bus.GICR_write_enable = 1'b0;
    cyc(4);
    chk("t4_quiet", {1'b0, bus.GIFR_output}, 4'h0);
    bus.pin_int0 = 1'b1; bus.pin_int1 = 1'b1; bus.pin_int2 = 1'b1;
    cyc(3);
    chk("t4_gifr", {1'b0, bus.GIFR_output}, 4'h7);
    chk("t4_vec1", {2'b00, bus.irq_vector}, 4'h1);
    for (int v = 1; v <= 3; v++) begin
      bus.irq_ack = 1'b1; bus.irq_ack_vector = 2'(v);
      cyc(1);
      bus.irq_ack = 1'b0;
      chk("t4_vec_next", {2'b00, bus.irq_vector}, 4'((v + 1) % 4));
    end

    // INT2 flag without enable, late enable, set beats GIFR clear.
    bus.GICR_write_enable = 1'b1; bus.GICR_input_data = 3'b000;
    bus.pin_int2 = 1'b0;
    cyc(1);
    bus.GICR_write_enable = 1'b0;
    cyc(4);
    chk("t5_quiet", {1'b0, bus.GIFR_output}, 4'h0);
    bus.pin_int2 = 1'b1;
    cyc(3);
    chk("t5_gifr", {1'b0, bus.GIFR_output}, 4'h1);
    chk("t5_noreq", {3'b000, bus.irq_request}, 4'h0);
    bus.GICR_write_enable = 1'b1; bus.GICR_input_data = 3'b001;
    cyc(1);
    bus.GICR_write_enable = 1'b0;
    chk("t5_req", {3'b000, bus.irq_request}, 4'h1);
    chk("t5_vec", {2'b00, bus.irq_vector}, 4'h3);
    bus.pin_int2 = 1'b0;
    cyc(4);
    bus.pin_int2 = 1'b1;
    cyc(2);
    bus.GIFR_write_enable = 1'b1; bus.GIFR_input_data = 3'b001;
    cyc(1);
    bus.GIFR_write_enable = 1'b0;
    chk("t5_set_wins", {1'b0, bus.GIFR_output}, 4'h1);
    bus.GIFR_write_enable = 1'b1; bus.GIFR_input_data = 3'b001;
    cyc(1);
    bus.GIFR_write_enable = 1'b0;
    chk("t5_w1c", {1'b0, bus.GIFR_output}, 4'h0);

    // Reset with INTF0 pending; the fill edge after reset is suppressed.
    bus.MCUCR_write_enable = 1'b1; bus.MCUCR_input_data = 4'b1101;
    bus.GICR_write_enable = 1'b1;  bus.GICR_input_data = 3'b010;
    cyc(1);
    bus.MCUCR_write_enable = 1'b0; bus.GICR_write_enable = 1'b0;
    bus.pin_int0 = 1'b0;
    cyc(3);
    chk("t6_pend", {1'b0, bus.GIFR_output}, 4'h2);
    clr = 1'b1; bus.pin_int0 = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("t6_gifr", {1'b0, bus.GIFR_output}, 4'h0);
    chk("t6_mcucr", bus.MCUCR_output, 4'h0);
    chk("t6_gicr", {1'b0, bus.GICR_output}, 4'h0);
    chk("t6_req", {3'b000, bus.irq_request}, 4'h0);
    chk("t6_vec", {2'b00, bus.irq_vector}, 4'h0);
    bus.MCUCR_write_enable = 1'b1; bus.MCUCR_input_data = 4'b0001;
    bus.GICR_write_enable = 1'b1;  bus.GICR_input_data = 3'b010;
    cyc(1);
    bus.MCUCR_write_enable = 1'b0; bus.GICR_write_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("t6_warm_gifr", {1'b0, bus.GIFR_output}, 4'h0);
      chk("t6_warm_req", {3'b000, bus.irq_request}, 4'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) bus.pin_int0 = ~bus.pin_int0;
      if ($urandom_range(0, 5) == 0) bus.pin_int1 = ~bus.pin_int1;
      if ($urandom_range(0, 5) == 0) bus.pin_int2 = ~bus.pin_int2;
      bus.MCUCR_write_enable = ($urandom_range(0, 9) == 0);
      bus.MCUCR_input_data   = 4'($urandom);
      bus.ISC2_write_enable  = ($urandom_range(0, 15) == 0);
      bus.ISC2_input_data    = 1'($urandom);
      bus.GICR_write_enable  = ($urandom_range(0, 9) == 0);
      bus.GICR_input_data    = 3'($urandom);
      bus.GIFR_write_enable  = ($urandom_range(0, 7) == 0);
      bus.GIFR_input_data    = 3'($urandom);
      bus.irq_ack            = ($urandom_range(0, 3) == 0);
      bus.irq_ack_vector     = 2'($urandom);
      clr                    = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
